// File: rtl/pipelined_adder.sv
// Valid/ready pipelined ripple adder; carry chain split into STAGES chunks.
// Define PIPELINED_ADDER_SUB_EN to add the sub port (a + ~b + 1).
module pipelined_adder #(
  parameter int WIDTH  = 11,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH + STAGES - 1) / STAGES;

  logic [STAGES-1:0] stg_v;
  logic [STAGES-1:0] stg_c;
  logic [WIDTH-1:0]  stg_a [STAGES];
  logic [WIDTH-1:0]  stg_b [STAGES];
  logic [WIDTH-1:0]  stg_s [STAGES];
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  b_in;
  logic              c_in;
  logic              r_acc;

  always_comb begin
    b_in = b;
    c_in = cin;
`ifdef PIPELINED_ADDER_SUB_EN
    if (sub) begin
      b_in = ~b;
      c_in = 1'b1;
    end
`endif
  end

  // A stage may load when empty or when everything downstream moves.
  always_comb begin
    rdy   = '0;
    r_acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r_acc  = ~stg_v[k] | r_acc;
      rdy[k] = r_acc;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k * CW < WIDTH) ? k * CW : WIDTH;
    localparam int HI = ((k + 1) * CW < WIDTH) ? (k + 1) * CW : WIDTH;

    logic             up_v;
    logic             up_c;
    logic [WIDTH-1:0] up_a;
    logic [WIDTH-1:0] up_b;
    logic [WIDTH-1:0] up_s;
    logic             add_c;
    logic [WIDTH-1:0] add_s;
    logic             v_q, v_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_a = a;
      assign up_b = b_in;
      assign up_s = '0;
      assign up_c = c_in;
    end else begin : g_body
      assign up_v = stg_v[k-1];
      assign up_a = stg_a[k-1];
      assign up_b = stg_b[k-1];
      assign up_s = stg_s[k-1];
      assign up_c = stg_c[k-1];
    end

    always_comb begin
      add_c = up_c;
      add_s = up_s;
      for (int i = LO; i < HI; i++) begin
        add_s[i] = up_a[i] ^ up_b[i] ^ add_c;
        add_c    = (up_a[i] & up_b[i]) | (add_c & (up_a[i] ^ up_b[i]));
      end
      v_d = v_q;
      a_d = a_q;
      b_d = b_q;
      s_d = s_q;
      c_d = c_q;
      if (rdy[k]) begin
        v_d = up_v;
        if (up_v) begin
          a_d = up_a;
          b_d = up_b;
          s_d = add_s;
          c_d = add_c;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
      end else begin
        v_q <= v_d;
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
        c_q <= c_d;
      end
    end

    assign stg_v[k] = v_q;
    assign stg_c[k] = c_q;
    assign stg_a[k] = a_q;
    assign stg_b[k] = b_q;
    assign stg_s[k] = s_q;
  end

  assign in_ready  = rdy[0];
  assign out_valid = stg_v[STAGES-1];
  assign sum       = stg_s[STAGES-1];
  assign cout      = stg_c[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=11) with STAGES 2, 1 and 11.
module tb_pipelined_adder;

  localparam int W   = 11;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         cin;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_ready, out_valid, cout;
  logic [W-1:0] sum;
  logic         r1_in_ready, r1_valid, r1_cout;
  logic [W-1:0] r1_sum;
  logic         r11_in_ready, r11_valid, r11_cout;
  logic [W-1:0] r11_sum;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  pipelined_adder #(.WIDTH(W), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1_in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(r1_valid), .out_ready(out_ready), .sum(r1_sum), .cout(r1_cout)
  );

  pipelined_adder #(.WIDTH(W), .STAGES(11)) dut_s11 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r11_in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(r11_valid), .out_ready(out_ready), .sum(r11_sum), .cout(r11_cout)
  );

  int         checks   = 0;
  int         failures = 0;
  int         n_out    = 0;
  logic [W:0] exp_q [$];
  bit         hold_prev = 1'b0;
  logic [W:0] held;
  logic [W:0] e;

  // Reference: integer arithmetic, result packed as {cout, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sb);
    int t;
    if (sb) begin
      t = int'(x) - int'(y);
      return {x >= y, W'((t + MOD) % MOD)};
    end
    t = int'(x) + int'(y) + int'(ci);
    return {t >= MOD, W'(t % MOD)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (in_valid && in_ready)
        exp_q.push_back(model(a, b, cin, sub));
      if (out_valid && !out_ready) begin
        if (hold_prev) chk("hold_stable", 64'({cout, sum}), 64'(held));
        hold_prev = 1'b1;
        held      = {cout, sum};
      end else begin
        hold_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'({cout, sum}), 64'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(input bit with_sub);
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
    if (with_sub) sub = 1'($urandom);
`endif
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int acc;
    int lat1;
    int lat11;
    logic r;

    rst       = 1'b1;
    out_ready = 1'b0;
    rand_ops(1'b0);
    in_valid  = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_sum", 64'(sum), 64'(0));
    chk("reset_cout", 64'(cout), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_s11_valid", 64'(r11_valid), 64'(0));

    // Full carry ripple, latency 2.
    tick();
    a = W'(11'h7FF); b = W'(11'h001); cin = 1'b0; sub = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ripple_lat1_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("ripple_lat2_valid", 64'(out_valid), 64'(1));
    chk("ripple_sum", 64'(sum), 64'(0));
    chk("ripple_cout", 64'(cout), 64'(1));
    tick();

    // Back-to-back streaming.
    base = n_out;
    for (int i = 0; i < 100; i++) begin
      rand_ops(1'b1);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_count", 64'(n_out - base), 64'(100));
    drain();

    // Backpressure: only two accepts into an empty 2-stage pipe.
    tick();
    base      = n_out;
    out_ready = 1'b0;
    rand_ops(1'b1);
    in_valid = 1'b1;
    acc      = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      r = in_ready;
      if (r) acc++;
      tick();
      if (r) rand_ops(1'b1);
    end
    chk("bp_accepts", 64'(acc), 64'(2));
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_accept_ready", 64'(in_ready), 64'(1));
    tick();
    drain();
    chk("bp_all_out", 64'(n_out - base), 64'(3));

    // Random valid/ready mix.
    for (int i = 0; i < 400; i++) begin
      rand_ops(1'b1);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    // Reset mid-flight discards everything.
    tick();
    out_ready = 1'b0;
    rand_ops(1'b0);
    in_valid = 1'b1;
    tick();
    rand_ops(1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_ghost", 64'(out_valid), 64'(0));
    end

    // STAGES=1 and STAGES=11 latency and result.
    tick();
    a = W'(11'h555); b = W'(11'h2AB); cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat1  = 0;
    lat11 = 0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (r1_valid && lat1 == 0) begin
        lat1 = n;
        chk("s1_result", 64'({r1_cout, r1_sum}), 64'({1'b1, 11'h001}));
      end
      if (r11_valid && lat11 == 0) begin
        lat11 = n;
        chk("s11_result", 64'({r11_cout, r11_sum}), 64'({1'b1, 11'h001}));
      end
    end
    chk("s1_latency", 64'(lat1), 64'(1));
    chk("s11_latency", 64'(lat11), 64'(11));
    drain();

`ifdef PIPELINED_ADDER_SUB_EN
    tick();
    a = W'(5); b = W'(7); cin = 1'b0; sub = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    a = W'(7); b = W'(5); cin = 1'b1;
    tick();
    in_valid = 1'b0;
    sub      = 1'b0;
    @(negedge clk);
    chk("sub_5_7", 64'({cout, sum}), 64'({1'b0, 11'h7FE}));
    @(negedge clk);
    chk("sub_7_5", 64'({cout, sum}), 64'({1'b1, 11'h002}));
    drain();
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
